// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin 4-to-1 mux arbiter.
// Holds the FSM state encoding, requester count, select width and the
// rotating-priority search helpers used by the arbiter core.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Rotating-priority search: first set request starting at last+1 (mod 4).
  // Offsets are scanned from farthest to nearest so the nearest match is the
  // final assignment; offset N_REQ wraps back to 'last' itself, which lets a
  // lone requester win again.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] last);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = last;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res.found = res.found;
      end
    end
    return res;
  endfunction

  // One-hot grant vector for a select index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus interface of the round-robin mux arbiter.
// Ports carried:
//   req       requester -> arbiter, one request bit per requester
//   in1..in4  requester -> arbiter, data of requesters 0..3
//   out_ready downstream -> arbiter, beat accepted
//   gnt       arbiter -> requesters, registered one-hot grant
//   sel       arbiter -> requesters, registered mux select
//   out_valid arbiter -> downstream, beat valid
//   out_data  arbiter -> downstream, selected data word
// Modports: master = requesters/downstream side, slave = arbiter.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [DATA_W-1:0] in4;
  logic              out_ready;
  logic [N_REQ-1:0]  gnt;
  logic [SEL_W-1:0]  sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output req, in1, in2, in3, in4, out_ready,
    input  gnt, sel, out_valid, out_data
  );

  modport slave (
    input  req, in1, in2, in3, in4, out_ready,
    output gnt, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux4to1_bus.sv
// Combinational 4-to-1 bus multiplexer.
// Ports: sel_i (2-bit select), in0_i..in3_i (DATA_W inputs), out_o (selected).
module mux4to1_bus #(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] in0_i,
  input  logic [DATA_W-1:0] in1_i,
  input  logic [DATA_W-1:0] in2_i,
  input  logic [DATA_W-1:0] in3_i,
  output logic [DATA_W-1:0] out_o
);

  // Select one of four data words.
  always_comb begin
    out_o = in0_i;
    case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      2'd3:    out_o = in3_i;
      default: out_o = in0_i;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-to-1 data mux.
// Grants one requester at a time, drives the mux select from the registered
// grant, and limits each grant to MAX_HOLD accepted beats before rotating.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   mux4_rr_arbiter_if.slave (req, in1..in4, out_ready in;
//         gnt, sel, out_valid, out_data out)
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_rr_arbiter_if.slave      bus
);

  localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0] last_q,  last_d;

  logic              valid_s;
  logic              accept_s;
  logic              release_s;
  pick_t             pick_s;
  logic [DATA_W-1:0] mux_data_s;

  // Handshake qualifiers and the round-robin candidate. While granted,
  // last_q equals the owner, so searching from last_q+1 advances past it.
  always_comb begin
    pick_s    = rr_pick(bus.req, last_q);
    valid_s   = (state_q == GRANT) && bus.req[sel_q];
    accept_s  = valid_s && bus.out_ready;
    release_s = (state_q == GRANT) &&
                (!bus.req[sel_q] || (accept_s && (cnt_q == CNT_LAST)));
  end

  // FSM, grant, select, beat counter and priority pointer next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_s.found) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_s.idx);
          sel_d   = pick_s.idx;
          last_d  = pick_s.idx;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (pick_s.found) begin
            gnt_d  = onehot(pick_s.idx);
            sel_d  = pick_s.idx;
            last_d = pick_s.idx;
          end else begin
            // No one waiting: drop the grant, keep sel so out_data stays defined.
            state_d = IDLE;
            gnt_d   = {N_REQ{1'b0}};
          end
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N_REQ{1'b0}};
        sel_d   = {SEL_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        last_d  = 2'd3;
      end
    endcase
  end

  // State registers; last resets to 3 so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= {N_REQ{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  mux4to1_bus #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_i (sel_q),
    .in0_i (bus.in1),
    .in1_i (bus.in2),
    .in2_i (bus.in3),
    .in3_i (bus.in4),
    .out_o (mux_data_s)
  );

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = mux_data_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed vector table, hand
// sequences for reset / contention / lone requester / async reset, and a
// randomized run against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din [4];

  int n_checks;
  int n_fail;

  // model state: owner index (-1 = idle), last granted index, beats taken
  int m_owner;
  int m_last;
  int m_cnt;

  mux4_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux4_rr_arbiter #(
    .DATA_W   (8),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.in1 = din[0];
  assign bus.in2 = din[1];
  assign bus.in3 = din[2];
  assign bus.in4 = din[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // first requester at offsets 1..4 after 'base'; -1 if none
  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rdy);
    int  p;
    bit  acc;
    if (m_owner < 0) begin
      p = pick(r, m_last);
      if (p >= 0) begin
        m_owner = p; m_last = p; m_cnt = 0;
      end
    end else begin
      acc = r[m_owner] && rdy;
      if (!r[m_owner] || (acc && m_cnt == MAX_HOLD - 1)) begin
        p = pick(r, m_owner);
        m_cnt = 0;
        m_owner = p;
        if (p >= 0) m_last = p;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] eg;
    logic       ev;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    ev = (m_owner >= 0) && bus.req[m_owner];
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'(ev));
    if (m_owner >= 0) begin
      chk({tag, "_sel"}, 32'(bus.sel), 32'(m_owner));
      chk({tag, "_dat"}, 32'(bus.out_data), 32'(din[m_owner]));
    end
  endtask

  // Assert reset with the given request pattern, check reset outputs,
  // then deassert on a falling edge.
  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    bus.req = r;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_vld", 32'(bus.out_valid), 32'h0);
    chk("rst_dat", 32'(bus.out_data), 32'(din[0]));
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.out_ready = 1'b0;
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;

    //            req      rdy   gnt      sel   vld   dat
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00};
    tbl[2]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[3]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[4]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[5]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[6]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
    tbl[8]  = '{4'b1100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
    tbl[9]  = '{4'b1000, 1'b1, 4'b0100, 2'd2, 1'b0, 8'h33};
    tbl[10] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 8'h44};
    tbl[11] = '{4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 8'h44};
    tbl[12] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00};
    tbl[13] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11};

    // Reset with all requesting, then requester 0 wins first.
    repeat (2) @(negedge clk);
    do_reset(4'b1111);
    @(posedge clk); #1;
    chk("rst_first_gnt", 32'(bus.gnt), 32'b0001);

    // Full contention: each owner holds exactly MAX_HOLD cycles, no gaps.
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      chk("contention_gnt", 32'(bus.gnt), 32'(4'b0001 << ((k / MAX_HOLD) % 4)));
    end

    // Directed vector table.
    @(negedge clk);
    do_reset(4'b0000);
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      bus.req = tbl[i].req;
      bus.out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_vld", i), 32'(bus.out_valid), 32'(tbl[i].vld));
      if (tbl[i].gnt != 4'b0000) begin
        chk($sformatf("tbl%0d_sel", i), 32'(bus.sel), 32'(tbl[i].sel));
        chk($sformatf("tbl%0d_dat", i), 32'(bus.out_data), 32'(tbl[i].dat));
      end
      @(posedge clk); #1;
    end

    // Lone requester keeps being re-granted across forced rotations.
    @(negedge clk);
    din[1] = 8'hA5;
    do_reset(4'b0010);
    @(posedge clk); #1;
    chk("single_gnt", 32'(bus.gnt), 32'b0010);
    chk("single_sel", 32'(bus.sel), 32'd1);
    chk("single_dat", 32'(bus.out_data), 32'hA5);
    chk("single_vld", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("single_hold_gnt", 32'(bus.gnt), 32'b0010);
    end

    // Asynchronous reset between clock edges mid-grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_sel", 32'(bus.sel), 32'h0);
    chk("async_vld", 32'(bus.out_valid), 32'h0);
    chk("async_dat", 32'(bus.out_data), 32'(din[0]));
    @(negedge clk);

    // Randomized run against the behavioural model.
    do_reset(4'b0000);
    @(posedge clk);
    model_step(bus.req, bus.out_ready);
    #1;
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      bus.req = r;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 4; b++) din[b] = 8'($urandom);
      @(negedge clk);
      model_check("rand");
      @(posedge clk);
      model_step(bus.req, bus.out_ready);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
